// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy encoding and
// default parameter values.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned CTRL_W_DEF     = 8;
  localparam bit          CLEAR_DATA_DEF = 1'b0;
  localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + control + data register with load, drop
// (invalidate after issue) and clear (flush) controls.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter bit          CLEAR_DATA = CLEAR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Control is zeroed whenever the entry goes invalid; data is only zeroed on
  // a flush, and only when CLEAR_DATA is set.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA) data_d = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = d_ctrl;
      data_d  = d_data;
    end else if (drop) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_ctrl  = ctrl_q;
  assign q_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with registered in_ready,
// flush, and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter bit          CLEAR_DATA = CLEAR_DATA_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e state_d, state_q;
  logic        in_ready_d, in_ready_q;
  logic [CNT_W-1:0] bubble_d, bubble_q;

  logic accept, issue;
  logic main_load, main_drop, main_clr, main_from_skid;
  logic skid_load, skid_clr;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign accept = in_valid & in_ready_q & ~flush;
  assign issue  = main_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && issue) begin
            main_load = 1'b1;
          end else if (issue) begin
            main_drop = 1'b1;
            state_d   = EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end
        end
        TWO: begin
          if (issue && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_comb begin
    main_d_data = main_from_skid ? skid_data : in_data;
    main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    bubble_d    = bubble_q;
    if (!main_valid && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      bubble_q   <= bubble_d;
    end
  end

  pipe_entry #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk    (CLK),
    .rst    (rst),
    .load   (main_load),
    .drop   (main_drop),
    .clear  (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_valid(main_valid),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_entry #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk    (CLK),
    .rst    (rst),
    .load   (skid_load),
    .drop   (1'b0),
    .clear  (skid_clr),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .q_valid(skid_valid),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign out_ctrl   = main_ctrl;
  assign bubble_cnt = bubble_q;

endmodule
